// File: rtl/writeback.sv
// writeback: EX/WB stage register, forwarding bus, GPR/FPR banks with two bypassed read ports; WRITEBACK_INSTRET_EN enables the instret counter
//   clk/rst                          clock, synchronous active-high reset
//   ex_valid/ex_busy                 retire request, execute busy (bubble)
//   ex_d/ex_rw/ex_rd                 result, target bank (00 none, 01 GPR, 10 FPR, 11 illegal), index
//   ra_addr/ra_data, rb_addr/rb_data read ports, addr[5] selects FPR
//   ew_d/ew_rw/ew_rd                 registered result, forwarding bus
//   err_rw                           sticky illegal-target flag
//   instret                          retired count, tied to 0 without WRITEBACK_INSTRET_EN
module writeback #(
  parameter int          SP_REG  = 29,
  parameter logic [31:0] SP_INIT = 32'h0003_FFFC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_busy,
  input  logic [31:0] ex_d,
  input  logic [1:0]  ex_rw,
  input  logic [4:0]  ex_rd,
  input  logic [5:0]  ra_addr,
  output logic [31:0] ra_data,
  input  logic [5:0]  rb_addr,
  output logic [31:0] rb_data,
  output logic [31:0] ew_d,
  output logic [1:0]  ew_rw,
  output logic [4:0]  ew_rd,
  output logic        err_rw,
  output logic [31:0] instret
);
  logic [31:0] gpr [32];
  logic [31:0] fpr [32];
  logic        cap;
  logic [1:0]  rw_next;
  assign cap = ex_valid & ~ex_busy;
  // illegal targets and writes to $zero retire as no-writes
  always_comb
    rw_next = (!cap || ex_rw == 2'b11 || (ex_rw == 2'b01 && ex_rd == 5'd0)) ? 2'b00 : ex_rw;
  always_ff @(posedge clk) begin
    if (rst) begin
      ew_d   <= '0;
      ew_rw  <= 2'b00;
      ew_rd  <= '0;
      err_rw <= 1'b0;
      for (int i = 0; i < 32; i++) begin
        gpr[i] <= (i == SP_REG) ? SP_INIT : 32'h0;
        fpr[i] <= 32'h0;
      end
    end else begin
      ew_rw <= rw_next;
      if (cap) begin
        ew_d  <= ex_d;
        ew_rd <= ex_rd;
        if (ex_rw == 2'b11) err_rw <= 1'b1;
      end
      if (ew_rw == 2'b01) gpr[ew_rd] <= ew_d;
      if (ew_rw == 2'b10) fpr[ew_rd] <= ew_d;
    end
  end
  // {a[5], ~a[5]} is the ew_rw code of the addressed bank
  function automatic logic [31:0] rd_port(input logic [5:0] a);
    rd_port = (!a[5] && a[4:0] == 5'd0) ? 32'h0 :
              (ew_rw == {a[5], ~a[5]} && ew_rd == a[4:0]) ? ew_d :
              a[5] ? fpr[a[4:0]] : gpr[a[4:0]];
  endfunction
  always_comb begin
    ra_data = rd_port(ra_addr);
    rb_data = rd_port(rb_addr);
  end
`ifdef WRITEBACK_INSTRET_EN
  logic [31:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (cap) cnt <= cnt + 32'd1;
  end
  assign instret = cnt;
`else
  assign instret = 32'h0;
`endif
endmodule

// File: doc/writeback.md
Name: writeback

Overview:
Final pipeline stage, directly downstream of the execute stage.
- Latches execute's result (d, destination bank, destination index) into the EX/WB pipeline register.
- Drives the ew_d/ew_rw/ew_rd forwarding bus back into execute.
- Owns the 32-entry integer (GPR) and 32-entry float (FPR) register banks; decode reads them through two bypassed read ports.
- Inserts bubbles while execute reports a busy UART operation.

Parameters:
SP_REG, 29, GPR index initialised to SP_INIT on reset
SP_INIT, 32'h0003_FFFC, reset value of GPR[SP_REG]

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
ex_valid  input  1  execute presents a retiring instruction this cycle
ex_busy  input  1  execute uart_state; 1 = instruction not complete, do not retire
ex_d  input  32  execute result d
ex_rw  input  2  write target: 00 none, 01 GPR, 10 FPR, 11 illegal
ex_rd  input  5  destination register index
ra_addr  input  6  read port A address; bit5 = bank (0 GPR, 1 FPR), bits4:0 = index
ra_data  output  32  read port A data
rb_addr  input  6  read port B address, same encoding
rb_data  output  32  read port B data
ew_d  output  32  registered result, forwarding bus to execute
ew_rw  output  2  registered write target (00/01/10 only)
ew_rd  output  5  registered destination index
err_rw  output  1  sticky flag: illegal ex_rw seen
instret  output  32  retired-instruction count (see Optional Feature)

Behaviour:
- Reset (rst=1 at posedge):
  - ew_d=0, ew_rw=2'b00, ew_rd=0, err_rw=0, instret=0.
  - All GPR/FPR entries = 0, except GPR[SP_REG]=SP_INIT.
  - Reset mid-operation discards any captured, uncommitted write.
- Stage register, each posedge when not in reset:
  - ex_busy=1: bubble. ew_rw<=00; ew_d/ew_rd hold. ex_busy takes priority over ex_valid.
  - ex_valid=1, ex_busy=0: capture ew_d<=ex_d, ew_rd<=ex_rd, ew_rw<=ex_rw, with two overrides:
    - ex_rw=01 with ex_rd=0 captures ew_rw=00, so $zero is never forwarded or written.
    - ex_rw=11 captures ew_rw=00 and sets err_rw<=1. err_rw is cleared only by rst.
  - ex_valid=0: bubble, as for ex_busy.
- Commit:
  - At the posedge after capture, if ew_rw=01 then GPR[ew_rd]<=ew_d; if ew_rw=10 then FPR[ew_rd]<=ew_d.
  - Result latency: ex_d at edge N appears on ew_* after edge N and lands in the bank at edge N+1.
  - Capture of a new instruction and commit of the previous one occur on the same edge, every cycle. No back-pressure toward execute beyond ex_busy.
- Read ports (combinational):
  - GPR index 0 always reads 0.
  - Otherwise, if ew_rw selects the same bank and ew_rd equals the address index, return ew_d (write-through bypass).
  - Otherwise return the bank entry.
  - A GPR and an FPR with the same index never alias.
  - Both ports may address the same register in the same cycle.
- instret: increments by 1 at each edge where a capture of a valid, non-busy instruction occurs, including ex_rw=00 and illegal ex_rw. Wraps 32'hFFFF_FFFF -> 0.

Optional Feature:
Macro WRITEBACK_INSTRET_EN.
- Defined: instret counter implemented as described above.
- Undefined: no counter flop; instret tied to 32'h0. All other behaviour is identical.

Test Plan:
- Reset with SP_INIT default -> ra_addr=6'd29 reads 32'h0003_FFFC; ra_addr=6'd5 and rb_addr=6'h25 read 0; ew_rw=00, err_rw=0.
- ex_valid=1, ex_rw=01, ex_rd=8, ex_d=32'hDEAD_BEEF for one cycle -> next cycle ew_rw=01, ew_rd=8, ra_addr=8 reads DEAD_BEEF via bypass, rb_addr=6'h28 (FPR 8) reads 0; cycle after, GPR[8] holds DEAD_BEEF with ew_rw=00.
- ex_rw=01, ex_rd=0, ex_d=5 -> ew_rw=00; ra_addr=0 reads 0; instret increments by 1 (macro on).
- ex_valid=1 with ex_busy=1 for 3 cycles, then ex_busy=0 with ex_rw=10, ex_rd=3, ex_d=32'h3F80_0000 -> no writes or instret change during busy; FPR[3]=32'h3F80_0000 two edges after release; instret +1.
- ex_rw=11, ex_d=7 -> err_rw=1 and stays 1; no bank changes; only rst clears err_rw.
- Back-to-back writes GPR[4]=1 then GPR[4]=2 on consecutive cycles -> ra_addr=4 reads 1, then 2, then 2; with the macro undefined, instret stays 0 throughout.
